oric_ram_arbiter: RTL and testbench
===================================

// Module: oric_ram_arbiter
// PURPOSE
//  Owns the single-port 64 KB main-RAM port and shares it between three requesters:
//   - the reset/clear fill sequencer;
//   - the Oric CPU/ULA bus, which cannot be stalled;
//   - the HPS ioctl loader, which is buffered and back-pressured.
//  Sits between the oricatmos core and the RAM array in the emu top.
//  Replaces the ad-hoc clr_addr logic and adds direct program/image loading into RAM.
// PARAMETERS
//  ADDR_W     16     RAM address width; clear length is 2**ADDR_W.
//  FILL       8'hFF  Byte written to every location during clear.
//  LOAD_BASE  16'h0  Offset added to ld_addr[15:0], modulo 2**ADDR_W.
//  FIFO_DEPTH 4      Loader FIFO entries; power of 2, >= 2.
// PORTS
//  clk_sys   in   1       System clock; single clock domain.
//  reset_n   in   1       Asynchronous, active-low reset.
//  clr_start in   1       One-cycle pulse: (re)start a full RAM clear.
//  clr_busy  out  1       High while a clear is in progress.
//  cpu_cs    in   1       CPU RAM select; owns the RAM on every cycle it is high, outside CLEAR.
//  cpu_we    in   1       CPU write enable, qualified by cpu_cs.
//  cpu_ad    in   ADDR_W  CPU address.
//  cpu_d     in   8       CPU write data.
//  cpu_q     out  8       CPU read data.
//  ld_active in   1       Loader session active (ioctl_download).
//  ld_wr     in   1       Loader byte strobe, one cycle.
//  ld_addr   in   25      Loader byte address.
//  ld_dout   in   8       Loader byte.
//  ld_wait   out  1       Loader back-pressure.
//  ld_err    out  1       Sticky flag: a loader byte was dropped.
//  ram_addr  out  ADDR_W  RAM address.
//  ram_din   out  8       RAM write data.
//  ram_we    out  1       RAM write strobe.
//  ram_q     in   8       RAM read data; synchronous, 1-cycle latency.
// BEHAVIOUR
//  Reset (async assert): state=CLEAR, cnt=0, arm=0, FIFO empty, ld_err=0, clr_busy=1.
//   - ram_we is gated by arm, so ram_we=0 while reset_n is low.
//   - arm goes to 1 on the first clk_sys edge after reset_n rises.
//   - A clear therefore follows every reset automatically.
//  FSM: IDLE, CLEAR.
//  CLEAR (arm=1):
//   - ram_addr=cnt, ram_din=FILL, ram_we=1 every cycle; cnt++.
//   - When cnt=all-ones: write, then go to IDLE.
//   - clr_busy falls on the cycle after the last write.
//   - Total = 2**ADDR_W write cycles.
//   - CPU is ignored: writes are discarded and cpu_q=FILL.
//   - The FIFO still accepts pushes but does not drain.
//  clr_start:
//   - In IDLE: go to CLEAR with cnt=0 on the next edge.
//   - In CLEAR: restart with cnt=0. FIFO contents are kept.
//  IDLE priority:
//   1. cpu_cs: ram_addr=cpu_ad, ram_din=cpu_d, ram_we=cpu_we.
//   2. Else, FIFO non-empty: pop head, ram_addr/ram_din from entry, ram_we=1.
//      At most one pop per cycle.
//   3. Else: ram_addr holds cpu_ad, ram_we=0.
//  The RAM-port mux is combinational from registered state, so CPU access gets 0 added cycles.
//  cpu_q = ram_q outside CLEAR; CPU read data is valid on the cycle after cpu_cs.
//  Loader push (ld_wr & ld_active):
//   - Entry = {ld_addr[15:0]+LOAD_BASE (wraps), ld_dout}.
//   - If ld_addr[24:ADDR_W]!=0, or FIFO full without a pop this cycle: drop, ld_err<=1.
//   - Push on a full FIFO with a pop in the same cycle is accepted (count unchanged).
//  ld_wait = (count >= FIFO_DEPTH-1); combinational from count.
//  ld_err clears on the rising edge of ld_active.
//  ld_active falling edge does not flush the FIFO; queued bytes still drain.
//  FIFO order is strict; a later push never overtakes an earlier one.
// STRUCTURE
//  oric_ram_pkg:
//   - state_t enum {IDLE, CLEAR};
//   - ld_entry_t struct {addr[ADDR_W], data[8]};
//   - FILL / LOAD_BASE defaults.
//  Sub-module oric_ram_fifo:
//   - sync FIFO: push/pop/full/empty/count;
//   - async active-low reset;
//   - first-word-fall-through head.
//  Top: FSM, clear counter, arm flop, RAM mux, ld_err logic.
// TESTING
//  T1 Release reset_n: 65536 writes of 0xFF to addresses 0..0xFFFF in order; clr_busy low after;
//     cpu_q=0xFF throughout.
//  T2 IDLE, CPU writes 0x5A to 0x1234, then reads 0x1234: cpu_q=0x5A one cycle after the read cs.
//  T3 cpu_cs held high; loader pushes 6 back-to-back bytes:
//     ld_wait rises at count 3, push 5 dropped and ld_err=1;
//     cpu_cs low: 4 queued bytes written 1/cycle in order.
//  T4 ld_addr=0x10000: byte dropped, ld_err=1, no RAM write;
//     ld_active toggles low then high: ld_err=0.
//  T5 FIFO holds 2 bytes (0x0400=0x11, 0x0401=0x22); clr_start pulsed:
//     full clear, then both bytes written; RAM reads 0x11/0x22.
//  T6 reset_n low at cnt=0x8000: ram_we=0 at once;
//     after release, clear restarts at 0 and runs 65536 cycles.

Source files
------------

// File: rtl/oric_ram_pkg.sv
// Shared types and defaults for the Oric main-RAM arbiter.
package oric_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Loader entries are carried at the widest supported RAM address width.
    localparam int          RAM_AW_MAX    = 16;
    localparam logic [7:0]  FILL_DEF      = 8'hFF;
    localparam logic [15:0] LOAD_BASE_DEF = 16'h0000;

    typedef struct packed {
        logic [RAM_AW_MAX-1:0] addr;
        logic [7:0]            data;
    } ld_entry_t;

    function automatic logic [RAM_AW_MAX-1:0] ld_target(input logic [24:0] ld_addr,
                                                         input logic [15:0] base);
        return ld_addr[15:0] + base;
    endfunction

endpackage

// File: rtl/oric_ram_arbiter_if.sv
// Bus bundle between the Oric core / HPS loader / RAM array and the arbiter.
interface oric_ram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              clr_start;
    logic              clr_busy;
    logic              cpu_cs;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_ad;
    logic [7:0]        cpu_d;
    logic [7:0]        cpu_q;
    logic              ld_active;
    logic              ld_wr;
    logic [24:0]       ld_addr;
    logic [7:0]        ld_dout;
    logic              ld_wait;
    logic              ld_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic [7:0]        ram_q;

    modport slave (
        input  clr_start, cpu_cs, cpu_we, cpu_ad, cpu_d,
               ld_active, ld_wr, ld_addr, ld_dout, ram_q,
        output clr_busy, cpu_q, ld_wait, ld_err, ram_addr, ram_din, ram_we
    );

    modport master (
        output clr_start, cpu_cs, cpu_we, cpu_ad, cpu_d,
               ld_active, ld_wr, ld_addr, ld_dout, ram_q,
        input  clr_busy, cpu_q, ld_wait, ld_err, ram_addr, ram_din, ram_we
    );

endinterface

// File: rtl/oric_ram_fifo.sv
// Small first-word-fall-through FIFO buffering loader bytes until the RAM port is free.
module oric_ram_fifo
    import oric_ram_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  ld_entry_t     din,
    output ld_entry_t     dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    ld_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is taken only when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/oric_ram_arbiter.sv
// Shares the single-port main RAM between the clear sequencer, the unstallable
// CPU/ULA bus and the buffered HPS loader.
module oric_ram_arbiter
    import oric_ram_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter logic [7:0]  FILL       = FILL_DEF,
    parameter logic [15:0] LOAD_BASE  = LOAD_BASE_DEF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    oric_ram_arbiter_if.slave  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              arm_q;
    logic              ld_err_q, ld_err_d;
    logic              ld_act_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    ld_entry_t         fifo_head, ld_entry;
    logic [15:0]       ld_sum;
    logic              ld_req, ld_in_range, ld_drop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR && arm_q) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
                state_d = IDLE;
            end
        end
    end

    // RAM port mux: combinational from registered state so the CPU sees no extra latency.
    always_comb begin
        fifo_pop     = 1'b0;
        bus.ram_addr = bus.cpu_ad;
        bus.ram_din  = bus.cpu_d;
        bus.ram_we   = 1'b0;
        bus.cpu_q    = bus.ram_q;
        if (state_q == CLEAR) begin
            bus.ram_addr = cnt_q;
            bus.ram_din  = FILL;
            bus.ram_we   = arm_q;
            bus.cpu_q    = FILL;
        end else if (bus.cpu_cs) begin
            bus.ram_we   = bus.cpu_we & arm_q;
        end else if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            bus.ram_addr = fifo_head.addr[ADDR_W-1:0];
            bus.ram_din  = fifo_head.data;
            bus.ram_we   = arm_q;
        end
    end

    always_comb begin
        ld_sum                       = ld_target(bus.ld_addr, LOAD_BASE);
        ld_entry                     = '0;
        ld_entry.addr[ADDR_W-1:0]    = ld_sum[ADDR_W-1:0];
        ld_entry.data                = bus.ld_dout;
        ld_req                       = bus.ld_wr & bus.ld_active;
        ld_in_range                  = ((bus.ld_addr >> ADDR_W) == 25'd0);
        fifo_push                    = ld_req & ld_in_range;
        ld_drop                      = ld_req & (~ld_in_range | (fifo_full & ~fifo_pop));
        // A new session starts with a clean error flag; a drop in that same cycle still counts.
        ld_err_d = ((bus.ld_active & ~ld_act_q) ? 1'b0 : ld_err_q) | ld_drop;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            arm_q    <= 1'b0;
            ld_err_q <= 1'b0;
            ld_act_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            arm_q    <= 1'b1;
            ld_err_q <= ld_err_d;
            ld_act_q <= bus.ld_active;
        end
    end

    oric_ram_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ld_entry),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.clr_busy = (state_q == CLEAR);
    assign bus.ld_err   = ld_err_q;
    assign bus.ld_wait  = (fifo_count >= CW'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Bench for oric_ram_arbiter: clear sequencing, CPU priority, loader FIFO and error flag.
module tb_oric_ram_arbiter;
    import oric_ram_pkg::*;

    localparam int          AW    = 10;
    localparam int          N     = 1 << AW;
    localparam logic [7:0]  FILLV = 8'hFF;
    localparam logic [15:0] BASE  = 16'h0100;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    oric_ram_arbiter_if #(.ADDR_W(AW)) bus ();

    oric_ram_arbiter #(
        .ADDR_W     (AW),
        .FILL       (FILLV),
        .LOAD_BASE  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write, one cycle of read latency.
    logic [7:0] ram [N];
    always @(posedge clk) begin
        bus.ram_q <= ram[bus.ram_addr];
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
    end

    typedef struct {
        logic          cs, we;
        logic [AW-1:0] ad;
        logic [7:0]    d;
        logic          act, wr;
        logic [24:0]   la;
        logic [7:0]    ld;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_din;
        logic          e_wait, e_err;
    } vec_t;

    typedef struct {
        int a;
        int d;
    } ent_t;

    vec_t vt [27];

    function automatic vec_t mk(input logic cs, we, input logic [AW-1:0] ad, input logic [7:0] d,
                                input logic act, wr, input logic [24:0] la, input logic [7:0] ld,
                                input logic e_we, input logic [AW-1:0] e_addr, input logic [7:0] e_din,
                                input logic e_wait, e_err);
        vec_t v;
        v.cs = cs; v.we = we; v.ad = ad; v.d = d; v.act = act; v.wr = wr; v.la = la; v.ld = ld;
        v.e_we = e_we; v.e_addr = e_addr; v.e_din = e_din; v.e_wait = e_wait; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic count_non_fill(output int n);
        n = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== FILLV) n++;
    endtask

    // Follows one clear; the CPU hammers the bus meanwhile and must be ignored.
    task automatic wait_clear(input int restart_at, output int writes);
        int exp_a = 0;
        int bad = 0;
        bit restarted = 0;
        writes = 0;
        for (int c = 0; c < 4 * N; c++) begin
            cyc();
            if (!bus.clr_busy) begin
                bus.cpu_cs = 1'b0;
                bus.cpu_we = 1'b0;
                break;
            end
            bus.cpu_cs    = 1'($urandom_range(0, 1));
            bus.cpu_we    = 1'b1;
            bus.cpu_ad    = AW'($urandom_range(0, N - 1));
            bus.cpu_d     = 8'h00;
            bus.clr_start = (restart_at >= 0 && !restarted && writes == restart_at);
            #1;
            if (bus.ram_we) begin
                if (bus.ram_addr !== AW'(exp_a) || bus.ram_din !== FILLV || bus.cpu_q !== FILLV) bad++;
                exp_a++;
                writes++;
            end
            if (bus.clr_start) begin
                restarted = 1'b1;
                exp_a     = 0;
            end
        end
        bus.clr_start = 1'b0;
        check("clear_bad_cycles", 32'(bad), 32'd0);
        check("clear_busy_end", 32'(bus.clr_busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    initial begin
        int w, nf, found;
        logic [7:0] ref_mem [N];
        ent_t q [$];
        ent_t e;
        bit   ref_err, prev_act, popped, have_q;
        logic [7:0] exp_q;
        logic cs, we, act, wr;
        logic [AW-1:0] ad;
        logic [7:0] d, ld;
        logic [24:0] la;
        int   e_addr, e_din;
        bit   e_we;

        vt[0]  = mk(1,0,10'h040,8'h00, 1,1,25'h000,8'hA0, 0,10'h040,8'h00, 0,0);
        vt[1]  = mk(1,0,10'h040,8'h00, 1,1,25'h001,8'hA1, 0,10'h040,8'h00, 0,0);
        vt[2]  = mk(1,0,10'h040,8'h00, 1,1,25'h002,8'hA2, 0,10'h040,8'h00, 0,0);
        vt[3]  = mk(1,0,10'h040,8'h00, 1,1,25'h003,8'hA3, 0,10'h040,8'h00, 1,0);
        vt[4]  = mk(1,0,10'h040,8'h00, 1,1,25'h004,8'hA4, 0,10'h040,8'h00, 1,0);
        vt[5]  = mk(1,0,10'h040,8'h00, 1,1,25'h005,8'hA5, 0,10'h040,8'h00, 1,1);
        vt[6]  = mk(0,0,10'h000,8'h00, 1,0,25'h000,8'h00, 1,10'h100,8'hA0, 1,1);
        vt[7]  = mk(0,0,10'h000,8'h00, 1,0,25'h000,8'h00, 1,10'h101,8'hA1, 1,1);
        vt[8]  = mk(0,0,10'h000,8'h00, 1,0,25'h000,8'h00, 1,10'h102,8'hA2, 0,1);
        vt[9]  = mk(0,0,10'h000,8'h00, 1,0,25'h000,8'h00, 1,10'h103,8'hA3, 0,1);
        vt[10] = mk(0,0,10'h155,8'h00, 1,0,25'h000,8'h00, 0,10'h155,8'h00, 0,1);
        vt[11] = mk(1,0,10'h200,8'h00, 1,1,25'h010,8'hB0, 0,10'h200,8'h00, 0,1);
        vt[12] = mk(1,0,10'h200,8'h00, 1,1,25'h011,8'hB1, 0,10'h200,8'h00, 0,1);
        vt[13] = mk(1,0,10'h200,8'h00, 1,1,25'h012,8'hB2, 0,10'h200,8'h00, 0,1);
        vt[14] = mk(1,0,10'h200,8'h00, 1,1,25'h013,8'hB3, 0,10'h200,8'h00, 1,1);
        vt[15] = mk(0,0,10'h000,8'h00, 1,1,25'h3FF,8'hB4, 1,10'h110,8'hB0, 1,1);
        vt[16] = mk(0,0,10'h000,8'h00, 1,0,25'h000,8'h00, 1,10'h111,8'hB1, 1,1);
        vt[17] = mk(0,0,10'h000,8'h00, 1,0,25'h000,8'h00, 1,10'h112,8'hB2, 1,1);
        vt[18] = mk(0,0,10'h000,8'h00, 1,0,25'h000,8'h00, 1,10'h113,8'hB3, 0,1);
        vt[19] = mk(0,0,10'h000,8'h00, 1,0,25'h000,8'h00, 1,10'h0FF,8'hB4, 0,1);
        vt[20] = mk(0,0,10'h0AA,8'h00, 0,0,25'h000,8'h00, 0,10'h0AA,8'h00, 0,1);
        vt[21] = mk(0,0,10'h0AA,8'h00, 1,0,25'h000,8'h00, 0,10'h0AA,8'h00, 0,1);
        vt[22] = mk(0,0,10'h0AA,8'h00, 1,1,25'h400,8'hC0, 0,10'h0AA,8'h00, 0,0);
        vt[23] = mk(0,0,10'h0AA,8'h00, 1,0,25'h000,8'h00, 0,10'h0AA,8'h00, 0,1);
        vt[24] = mk(0,0,10'h0AA,8'h00, 0,1,25'h020,8'hC1, 0,10'h0AA,8'h00, 0,1);
        vt[25] = mk(0,0,10'h0AA,8'h00, 1,0,25'h000,8'h00, 0,10'h0AA,8'h00, 0,1);
        vt[26] = mk(0,0,10'h0AA,8'h00, 1,0,25'h000,8'h00, 0,10'h0AA,8'h00, 0,0);

        for (int i = 0; i < N; i++) ram[i] = 8'h00;
        bus.clr_start = 0; bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_ad = '0; bus.cpu_d = 0;
        bus.ld_active = 0; bus.ld_wr = 0; bus.ld_addr = '0; bus.ld_dout = 0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_clr_busy", 32'(bus.clr_busy), 32'd1);
        check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("rst_ld_err", 32'(bus.ld_err), 32'd0);
        check("rst_ld_wait", 32'(bus.ld_wait), 32'd0);
        cyc();
        check("rst_hold_ram_we", 32'(bus.ram_we), 32'd0);
        cyc();
        reset_n = 1'b1;

        // T1: clear after reset
        wait_clear(-1, w);
        check("t1_clear_writes", 32'(w), 32'(N));
        count_non_fill(nf);
        check("t1_ram_all_fill", 32'(nf), 32'd0);

        // T2: CPU write then read back
        bus.cpu_cs = 1; bus.cpu_we = 1; bus.cpu_ad = 10'h234; bus.cpu_d = 8'h5A;
        #1;
        check("t2_wr_we", 32'(bus.ram_we), 32'd1);
        check("t2_wr_addr", 32'(bus.ram_addr), 32'h234);
        check("t2_wr_din", 32'(bus.ram_din), 32'h5A);
        cyc();
        bus.cpu_we = 0;
        #1;
        check("t2_rd_we", 32'(bus.ram_we), 32'd0);
        cyc();
        bus.cpu_cs = 0; bus.ld_active = 1;
        #1;
        check("t2_cpu_q", 32'(bus.cpu_q), 32'h5A);

        // T3/T4: loader back-pressure, drops, drain order, error flag
        for (int i = 0; i < 27; i++) begin
            cyc();
            bus.cpu_cs = vt[i].cs; bus.cpu_we = vt[i].we; bus.cpu_ad = vt[i].ad; bus.cpu_d = vt[i].d;
            bus.ld_active = vt[i].act; bus.ld_wr = vt[i].wr; bus.ld_addr = vt[i].la; bus.ld_dout = vt[i].ld;
            #1;
            check($sformatf("vec%0d_we", i), 32'(bus.ram_we), 32'(vt[i].e_we));
            check($sformatf("vec%0d_addr", i), 32'(bus.ram_addr), 32'(vt[i].e_addr));
            if (vt[i].e_we) check($sformatf("vec%0d_din", i), 32'(bus.ram_din), 32'(vt[i].e_din));
            check($sformatf("vec%0d_wait", i), 32'(bus.ld_wait), 32'(vt[i].e_wait));
            check($sformatf("vec%0d_err", i), 32'(bus.ld_err), 32'(vt[i].e_err));
        end

        // T5: queued bytes survive a (restarted) clear and land afterwards
        cyc();
        bus.cpu_cs = 1; bus.cpu_we = 0; bus.cpu_ad = 10'h300;
        bus.ld_wr = 1; bus.ld_addr = 25'h200; bus.ld_dout = 8'h11;
        cyc();
        bus.ld_addr = 25'h201; bus.ld_dout = 8'h22;
        cyc();
        bus.ld_wr = 0; bus.clr_start = 1;
        #1;
        check("t5_wait_two", 32'(bus.ld_wait), 32'd0);
        wait_clear(100, w);
        check("t5_clear_writes", 32'(w), 32'(101 + N));
        #1;
        check("t5_pop0_we", 32'(bus.ram_we), 32'd1);
        check("t5_pop0_addr", 32'(bus.ram_addr), 32'h300);
        check("t5_pop0_din", 32'(bus.ram_din), 32'h11);
        cyc();
        check("t5_pop1_addr", 32'(bus.ram_addr), 32'h301);
        check("t5_pop1_din", 32'(bus.ram_din), 32'h22);
        cyc();
        bus.cpu_cs = 1; bus.cpu_we = 0; bus.cpu_ad = 10'h300;
        cyc();
        bus.cpu_ad = 10'h301;
        #1;
        check("t5_rd_300", 32'(bus.cpu_q), 32'h11);
        cyc();
        bus.cpu_cs = 0;
        #1;
        check("t5_rd_301", 32'(bus.cpu_q), 32'h22);

        // Randomised traffic against a queue-based reference model
        for (int i = 0; i < N; i++) ref_mem[i] = FILLV;
        ref_mem[10'h300] = 8'h11;
        ref_mem[10'h301] = 8'h22;
        q.delete();
        ref_err = 0; prev_act = 1; have_q = 0; exp_q = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            cs  = ($urandom_range(0, 9) < 4);
            we  = 1'($urandom_range(0, 1));
            ad  = AW'($urandom_range(0, N - 1));
            d   = 8'($urandom_range(0, 255));
            act = ($urandom_range(0, 29) == 0) ? ~prev_act : prev_act;
            wr  = 1'($urandom_range(0, 1)) && !(act && !prev_act);
            la  = 25'($urandom_range(0, N - 1));
            if ($urandom_range(0, 19) == 0) la = la | (25'd1 << $urandom_range(AW, 24));
            ld  = 8'($urandom_range(0, 255));
            bus.cpu_cs = cs; bus.cpu_we = we; bus.cpu_ad = ad; bus.cpu_d = d;
            bus.ld_active = act; bus.ld_wr = wr; bus.ld_addr = la; bus.ld_dout = ld;

            check("rnd_wait", 32'(bus.ld_wait), 32'(q.size() >= DEPTH - 1));
            check("rnd_err", 32'(bus.ld_err), 32'(ref_err));
            popped = 0;
            if (cs) begin
                e_we = we; e_addr = int'(ad); e_din = int'(d);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                popped = 1; e_we = 1; e_addr = e.a; e_din = e.d;
            end else begin
                e_we = 0; e_addr = int'(ad); e_din = 0;
            end
            #1;
            check("rnd_we", 32'(bus.ram_we), 32'(e_we));
            check("rnd_addr", 32'(bus.ram_addr), 32'(e_addr));
            if (e_we) check("rnd_din", 32'(bus.ram_din), 32'(e_din));
            if (have_q) check("rnd_cpu_q", 32'(bus.cpu_q), 32'(exp_q));
            exp_q = ref_mem[e_addr];
            have_q = 1;
            if (e_we) ref_mem[e_addr] = 8'(e_din);
            if (act && !prev_act) ref_err = 0;
            if (wr && act) begin
                if (la >= 25'(N) || q.size() == DEPTH) begin
                    ref_err = 1;
                end else begin
                    e.a = (int'(la[15:0]) + int'(BASE)) % N;
                    e.d = int'(ld);
                    q.push_back(e);
                end
            end
            if (popped && q.size() > DEPTH) ref_err = 1;
            prev_act = act;
        end

        // T6: reset in the middle of a clear, with loader bytes queued
        cyc();
        bus.cpu_cs = 0; bus.ld_wr = 0; bus.ld_active = 1;
        for (int i = 0; i < 6; i++) cyc();
        bus.cpu_cs = 1; bus.cpu_we = 0;
        for (int i = 0; i < 3; i++) begin
            bus.ld_wr = 1; bus.ld_addr = 25'(i); bus.ld_dout = 8'h33;
            cyc();
        end
        bus.ld_wr = 0; bus.clr_start = 1;
        #1;
        check("t6_wait_before", 32'(bus.ld_wait), 32'd1);
        cyc();
        bus.clr_start = 0; bus.cpu_cs = 0;
        found = 0;
        for (int c = 0; c < 2 * N; c++) begin
            #1;
            if (bus.ram_we && bus.ram_addr == AW'(N / 2)) begin
                found = 1;
                break;
            end
            cyc();
        end
        check("t6_reached_mid", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_we", 32'(bus.ram_we), 32'd0);
        check("t6_rst_busy", 32'(bus.clr_busy), 32'd1);
        check("t6_rst_wait", 32'(bus.ld_wait), 32'd0);
        check("t6_rst_err", 32'(bus.ld_err), 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        wait_clear(-1, w);
        check("t6_clear_writes", 32'(w), 32'(N));
        #1;
        check("t6_fifo_flushed", 32'(bus.ram_we), 32'd0);
        count_non_fill(nf);
        check("t6_ram_all_fill", 32'(nf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
